fib_scheduler: RTL and testbench
================================

# fib_scheduler

Sequences and shares the single FIB lookup datapath (`fib`) between its two requesters: the outgoing-interest path from the PIT and the incoming-data path. Grants one request at a time (round-robin on contention), drives the FIB's `pit_in_*`/`fib_out_bit` or `data_in_*`/`data_ready` inputs with the correct pulse/level discipline, waits for completion or timeout, and returns a one-cycle done pulse with status and result to the granted requester.

## Interface
- `PREFIX_W`, 64: prefix width.
- `LEN_W`, 6: prefix length width.
- `TIMEOUT`, 32: max cycles from issue to completion before abort; legal range 2..255.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pit_req` in 1: outgoing lookup request (level, held until `pit_ack`).
- `pit_req_prefix` in PREFIX_W / `pit_req_len` in LEN_W: outgoing request payload.
- `pit_ack` out 1: one-cycle pulse; payload captured.
- `data_req` in 1 / `data_req_prefix` in PREFIX_W / `data_req_len` in LEN_W / `data_ack` out 1: same for the incoming path.
- `pit_in_prefix` out PREFIX_W, `pit_in_len` out LEN_W, `fib_out_bit` out 1: to FIB, outgoing.
- `data_in_prefix` out PREFIX_W, `data_in_len` out LEN_W, `data_ready` out 1: to FIB, incoming.
- `prefix_ready` in 1: FIB outgoing lookup complete.
- `longest_matching_prefix` in PREFIX_W, `longest_matching_prefix_len` in LEN_W: FIB result, valid with `prefix_ready`.
- `pit_accept` in 1 / `pit_rejected` in 1: PIT verdict on incoming packet.
- `pit_done` out 1 / `data_done` out 1: one-cycle completion pulse per requester.
- `done_status` out 2: 0 OK, 1 REJECT, 2 TIMEOUT; valid with either done.
- `result_prefix` out PREFIX_W / `result_len` out LEN_W: latched FIB result; held until next outgoing completion.

## Operation
- States: IDLE, OUT_ISSUE, OUT_WAIT, IN_ISSUE, IN_WAIT, GAP.
- IDLE: if exactly one req high, grant it; if both, grant the one not granted last (`last_grant`, reset = data so PIT wins first). On grant: payload registered, ack pulses next cycle, go to *_ISSUE.
- Zero-length request (`len == 0`): granted and acked normally but skips FIB; goes straight to GAP with done, status REJECT.
- OUT_ISSUE (1 cycle): `fib_out_bit`=1, `pit_in_*` = captured payload. → OUT_WAIT.
- OUT_WAIT: `fib_out_bit`=0, `pit_in_*` held. `prefix_ready` → latch result, status OK, → GAP. `pit_accept/rejected` ignored.
- IN_ISSUE (1 cycle) / IN_WAIT: `data_ready`=1 and `data_in_*` held across both. `pit_rejected` → REJECT; `pit_accept` → OK; both same cycle → REJECT. `prefix_ready` ignored. → GAP.
- Timeout counter clears at *_ISSUE, increments each cycle; reaching TIMEOUT in *_WAIT → status TIMEOUT, → GAP. Completion in the same cycle as expiry wins (status from completion).
- GAP (1 cycle): all FIB-facing outputs 0, done pulse for the granted side, `last_grant` updated. → IDLE.
- A req still high in GAP/IDLE is a new request; ack is never issued while a grant is outstanding.

## Timing
- Reset (async, immediate): state IDLE; all outputs 0, including `result_*`, `done_status`; `last_grant`=data; counter 0. Reset mid-transaction aborts with no done pulse.
- Req sampled high in IDLE at edge N → ack and *_ISSUE at N+1; FIB inputs valid from N+1.
- Completion sampled at edge M → done and GAP at M+1, IDLE at M+2; earliest next ack at M+3.
- Minimum request-to-done: 3 cycles with 1-cycle FIB response; TIMEOUT expiry gives done at issue+TIMEOUT+1.
- All outputs registered; no combinational input→output paths.

## Structure
- `fib_sched_pkg`: state enum, status codes (OK/REJECT/TIMEOUT), grant-side enum, PREFIX_W/LEN_W defaults.
- Sub-module `fib_sched_timer`: clearable saturating counter with `expired` flag, width from TIMEOUT.

## Test plan
- Outgoing only: prefix 64'h0000FFFF0000FFFF, len 10; FIB `prefix_ready` 2 cycles after issue with len 8 -> `fib_out_bit` exactly 1 cycle, `pit_done` with status 0, `result_len`=8.
- Incoming, PIT rejects after 5 cycles -> `data_ready` high 6 cycles, `data_done` status 1; then accept case -> status 0.
- Both reqs asserted same cycle from reset, held -> grants PIT, data, PIT, data alternately; never two grants outstanding.
- No response, TIMEOUT=32 -> done at issue+33 with status 2; FIB inputs zero in GAP.
- Edge cases: len 0 -> REJECT without FIB activity; `pit_accept`+`pit_rejected` together -> REJECT; completion on expiry cycle -> completion status.
- Reset asserted in OUT_WAIT -> all outputs 0 immediately, no done pulse, next grant goes to PIT.

Source files
------------

// File: rtl/fib_sched_pkg.sv
// rtl/fib_sched_pkg.sv - shared types and defaults for the FIB lookup scheduler
package fib_sched_pkg;

    localparam int DEF_PREFIX_W = 64;
    localparam int DEF_LEN_W    = 6;
    localparam int DEF_TIMEOUT  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OUT_ISSUE,
        ST_OUT_WAIT,
        ST_IN_ISSUE,
        ST_IN_WAIT,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_REJECT  = 2'd1,
        STATUS_TIMEOUT = 2'd2
    } status_t;

    typedef enum logic {
        SIDE_PIT  = 1'b0,
        SIDE_DATA = 1'b1
    } side_t;

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
    function automatic side_t pick_side(input logic pit, input logic data, input side_t last);
        side_t side;
        if (pit && data) begin
            if (last == SIDE_PIT) begin
                side = SIDE_DATA;
            end else begin
                side = SIDE_PIT;
            end
        end else if (pit) begin
            side = SIDE_PIT;
        end else begin
            side = SIDE_DATA;
        end
        return side;
    endfunction

endpackage

// File: rtl/fib_sched_timer.sv
// rtl/fib_sched_timer.sv - clearable saturating cycle counter with expiry flag
module fib_sched_timer #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Count up from a clear, parking at TIMEOUT so an idle scheduler never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != CW'(TIMEOUT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/fib_scheduler.sv
// rtl/fib_scheduler.sv - arbitrates PIT and data requesters onto the shared FIB datapath
module fib_scheduler
    import fib_sched_pkg::*;
#(
    parameter int PREFIX_W = DEF_PREFIX_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pit_req,
    input  logic [PREFIX_W-1:0] pit_req_prefix,
    input  logic [LEN_W-1:0]    pit_req_len,
    output logic                pit_ack,
    input  logic                data_req,
    input  logic [PREFIX_W-1:0] data_req_prefix,
    input  logic [LEN_W-1:0]    data_req_len,
    output logic                data_ack,
    output logic [PREFIX_W-1:0] pit_in_prefix,
    output logic [LEN_W-1:0]    pit_in_len,
    output logic                fib_out_bit,
    output logic [PREFIX_W-1:0] data_in_prefix,
    output logic [LEN_W-1:0]    data_in_len,
    output logic                data_ready,
    input  logic                prefix_ready,
    input  logic [PREFIX_W-1:0] longest_matching_prefix,
    input  logic [LEN_W-1:0]    longest_matching_prefix_len,
    input  logic                pit_accept,
    input  logic                pit_rejected,
    output logic                pit_done,
    output logic                data_done,
    output logic [1:0]          done_status,
    output logic [PREFIX_W-1:0] result_prefix,
    output logic [LEN_W-1:0]    result_len
);

    state_t              state, state_n;
    side_t               grant_side, grant_side_n;
    side_t               last_grant, last_grant_n;
    logic                pit_ack_n, data_ack_n, pit_done_n, data_done_n;
    logic                fib_out_bit_n, data_ready_n;
    logic [PREFIX_W-1:0] pit_in_prefix_n, data_in_prefix_n, result_prefix_n;
    logic [LEN_W-1:0]    pit_in_len_n, data_in_len_n, result_len_n;
    logic [1:0]          done_status_n;
    logic                timer_clear;
    logic                expired;

    fib_sched_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .expired (expired)
    );

    // Next state and next value of every registered output; FIB-facing payload
    // registers double as the captured request and are zeroed on completion.
    always_comb begin
        state_n          = state;
        grant_side_n     = grant_side;
        last_grant_n     = last_grant;
        pit_ack_n        = 1'b0;
        data_ack_n       = 1'b0;
        pit_done_n       = 1'b0;
        data_done_n      = 1'b0;
        fib_out_bit_n    = 1'b0;
        data_ready_n     = data_ready;
        pit_in_prefix_n  = pit_in_prefix;
        pit_in_len_n     = pit_in_len;
        data_in_prefix_n = data_in_prefix;
        data_in_len_n    = data_in_len;
        done_status_n    = done_status;
        result_prefix_n  = result_prefix;
        result_len_n     = result_len;
        timer_clear      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pit_req || data_req) begin
                    grant_side_n = pick_side(pit_req, data_req, last_grant);
                    if (grant_side_n == SIDE_PIT) begin
                        pit_ack_n = 1'b1;
                        if (pit_req_len == '0) begin
                            pit_done_n    = 1'b1;
                            done_status_n = STATUS_REJECT;
                            state_n       = ST_GAP;
                        end else begin
                            pit_in_prefix_n = pit_req_prefix;
                            pit_in_len_n    = pit_req_len;
                            fib_out_bit_n   = 1'b1;
                            timer_clear     = 1'b1;
                            state_n         = ST_OUT_ISSUE;
                        end
                    end else begin
                        data_ack_n = 1'b1;
                        if (data_req_len == '0) begin
                            data_done_n   = 1'b1;
                            done_status_n = STATUS_REJECT;
                            state_n       = ST_GAP;
                        end else begin
                            data_in_prefix_n = data_req_prefix;
                            data_in_len_n    = data_req_len;
                            data_ready_n     = 1'b1;
                            timer_clear      = 1'b1;
                            state_n          = ST_IN_ISSUE;
                        end
                    end
                end
            end
            ST_OUT_ISSUE: begin
                state_n = ST_OUT_WAIT;
            end
            ST_OUT_WAIT: begin
                if (prefix_ready || expired) begin
                    pit_done_n      = 1'b1;
                    pit_in_prefix_n = '0;
                    pit_in_len_n    = '0;
                    state_n         = ST_GAP;
                    if (prefix_ready) begin
                        done_status_n   = STATUS_OK;
                        result_prefix_n = longest_matching_prefix;
                        result_len_n    = longest_matching_prefix_len;
                    end else begin
                        done_status_n = STATUS_TIMEOUT;
                    end
                end
            end
            ST_IN_ISSUE: begin
                state_n = ST_IN_WAIT;
            end
            ST_IN_WAIT: begin
                if (pit_rejected || pit_accept || expired) begin
                    data_done_n      = 1'b1;
                    data_ready_n     = 1'b0;
                    data_in_prefix_n = '0;
                    data_in_len_n    = '0;
                    state_n          = ST_GAP;
                    if (pit_rejected) begin
                        done_status_n = STATUS_REJECT;
                    end else if (pit_accept) begin
                        done_status_n = STATUS_OK;
                    end else begin
                        done_status_n = STATUS_TIMEOUT;
                    end
                end
            end
            ST_GAP: begin
                last_grant_n = grant_side;
                state_n      = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops everything and favours PIT next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            grant_side     <= SIDE_DATA;
            last_grant     <= SIDE_DATA;
            pit_ack        <= 1'b0;
            data_ack       <= 1'b0;
            pit_done       <= 1'b0;
            data_done      <= 1'b0;
            fib_out_bit    <= 1'b0;
            data_ready     <= 1'b0;
            pit_in_prefix  <= '0;
            pit_in_len     <= '0;
            data_in_prefix <= '0;
            data_in_len    <= '0;
            done_status    <= '0;
            result_prefix  <= '0;
            result_len     <= '0;
        end else begin
            state          <= state_n;
            grant_side     <= grant_side_n;
            last_grant     <= last_grant_n;
            pit_ack        <= pit_ack_n;
            data_ack       <= data_ack_n;
            pit_done       <= pit_done_n;
            data_done      <= data_done_n;
            fib_out_bit    <= fib_out_bit_n;
            data_ready     <= data_ready_n;
            pit_in_prefix  <= pit_in_prefix_n;
            pit_in_len     <= pit_in_len_n;
            data_in_prefix <= data_in_prefix_n;
            data_in_len    <= data_in_len_n;
            done_status    <= done_status_n;
            result_prefix  <= result_prefix_n;
            result_len     <= result_len_n;
        end
    end

endmodule

// File: tb/tb_fib_scheduler.sv
// tb/tb_fib_scheduler.sv - randomized and directed self-checking bench for fib_scheduler
module tb_fib_scheduler;

    localparam int PW = 64;
    localparam int LW = 6;
    localparam int T  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pit_req = 1'b0, data_req = 1'b0;
    logic [PW-1:0] pit_req_prefix = '0, data_req_prefix = '0;
    logic [LW-1:0] pit_req_len = '0, data_req_len = '0;
    logic          pit_ack, data_ack, fib_out_bit, data_ready, pit_done, data_done;
    logic [PW-1:0] pit_in_prefix, data_in_prefix, result_prefix;
    logic [LW-1:0] pit_in_len, data_in_len, result_len;
    logic [1:0]    done_status;
    logic          prefix_ready = 1'b0, pit_accept = 1'b0, pit_rejected = 1'b0;
    logic [PW-1:0] longest_matching_prefix = '0;
    logic [LW-1:0] longest_matching_prefix_len = '0;

    fib_scheduler #(.PREFIX_W(PW), .LEN_W(LW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .pit_req(pit_req), .pit_req_prefix(pit_req_prefix), .pit_req_len(pit_req_len), .pit_ack(pit_ack),
        .data_req(data_req), .data_req_prefix(data_req_prefix), .data_req_len(data_req_len), .data_ack(data_ack),
        .pit_in_prefix(pit_in_prefix), .pit_in_len(pit_in_len), .fib_out_bit(fib_out_bit),
        .data_in_prefix(data_in_prefix), .data_in_len(data_in_len), .data_ready(data_ready),
        .prefix_ready(prefix_ready), .longest_matching_prefix(longest_matching_prefix),
        .longest_matching_prefix_len(longest_matching_prefix_len),
        .pit_accept(pit_accept), .pit_rejected(pit_rejected),
        .pit_done(pit_done), .data_done(data_done), .done_status(done_status),
        .result_prefix(result_prefix), .result_len(result_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction-level model: one outstanding grant with its grant edge, payload and response plan.
    int            e = 0;
    bit            busy = 0;
    bit            side = 0;
    logic [PW-1:0] t_prefix = '0;
    logic [LW-1:0] t_len = '0;
    int            g = 0, resp_edge = -1, resp_kind = 0, free_edge = 0;
    bit            last_side = 1;
    logic [PW-1:0] m_res_p = '0;
    logic [LW-1:0] m_res_l = '0;
    bit            exp_pit_ack, exp_data_ack, exp_pit_done, exp_data_done;
    int            exp_status = 0;
    bit            done_seen = 0, grant_seen = 0;
    int            last_g = 0, last_c = 0;
    logic [1:0]    last_dut_status = '0;
    int            fob_count = 0, dr_count = 0;
    bit            grant_log[$];
    int            force_delay = -2, force_kind = -1, force_res_len = -1;
    bit            gen_on = 0, hold_both = 0, noise_on = 1;

    function automatic logic [LW-1:0] rand_len();
        if ($urandom_range(0, 5) == 0) return '0;
        return LW'($urandom_range(1, 63));
    endfunction

    task automatic finish_txn(input int st);
        if (side) exp_data_done = 1; else exp_pit_done = 1;
        exp_status = st;
        last_side  = side;
        last_c     = e;
        free_edge  = e + 2;
        done_seen  = 1;
        busy       = 0;
    endtask

    task automatic model_reset();
        busy = 0; last_side = 1; m_res_p = '0; m_res_l = '0; free_edge = 0;
        exp_pit_ack = 0; exp_data_ack = 0; exp_pit_done = 0; exp_data_done = 0;
    endtask

    // Apply the effect of the edge just taken, using the inputs the DUT saw at it.
    task automatic model_update();
        int delay;
        bit fin;
        int st;
        e++;
        exp_pit_ack = 0; exp_data_ack = 0; exp_pit_done = 0; exp_data_done = 0;
        if (busy && e >= g + 2) begin
            fin = 0; st = 0;
            if (!side) begin
                if (prefix_ready) begin
                    fin = 1; st = 0; m_res_p = longest_matching_prefix; m_res_l = longest_matching_prefix_len;
                end
            end else if (pit_rejected) begin
                fin = 1; st = 1;
            end else if (pit_accept) begin
                fin = 1; st = 0;
            end
            if (!fin && e == g + T + 1) begin
                fin = 1; st = 2;
            end
            if (fin) finish_txn(st);
        end else if (!busy && e >= free_edge && (pit_req || data_req)) begin
            side = !(pit_req && (!data_req || last_side));
            g = e; last_g = e; grant_seen = 1;
            grant_log.push_back(side);
            if (side) begin
                exp_data_ack = 1; t_prefix = data_req_prefix; t_len = data_req_len; data_req = 0;
            end else begin
                exp_pit_ack = 1; t_prefix = pit_req_prefix; t_len = pit_req_len; pit_req = 0;
            end
            if (t_len == 0) begin
                finish_txn(1);
            end else begin
                busy = 1;
                if (force_delay != -2) delay = force_delay;
                else begin
                    case ($urandom_range(0, 9))
                        0: delay = -1;
                        1: delay = T;
                        2: delay = T + 1 + int'($urandom_range(0, 2));
                        default: delay = int'($urandom_range(1, 6));
                    endcase
                end
                resp_edge = (delay < 0) ? -1 : g + 1 + delay;
                resp_kind = (force_kind >= 0) ? force_kind : (side ? int'($urandom_range(1, 3)) : 0);
            end
        end
    endtask

    // Responder inputs for the coming edge: the planned completion plus noise the DUT must ignore.
    task automatic drive_responder();
        prefix_ready = 0; pit_accept = 0; pit_rejected = 0;
        longest_matching_prefix = {$urandom(), $urandom()};
        longest_matching_prefix_len = (force_res_len >= 0) ? LW'(force_res_len) : LW'($urandom());
        if (busy && e + 1 >= g + 2) begin
            if (!side) begin
                prefix_ready = (e + 1 == resp_edge);
                if (noise_on) begin
                    pit_accept = 1'($urandom_range(0, 1)); pit_rejected = 1'($urandom_range(0, 1));
                end
            end else begin
                pit_rejected = (e + 1 == resp_edge) && (resp_kind == 1 || resp_kind == 3);
                pit_accept   = (e + 1 == resp_edge) && (resp_kind == 2 || resp_kind == 3);
                if (noise_on) prefix_ready = 1'($urandom_range(0, 1));
            end
        end else if (noise_on && !busy) begin
            prefix_ready = 1'($urandom_range(0, 1));
            pit_accept   = 1'($urandom_range(0, 1));
            pit_rejected = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic gen_requests();
        if (gen_on || hold_both) begin
            if (!pit_req && (hold_both || $urandom_range(0, 3) == 0)) begin
                pit_req = 1; pit_req_prefix = {$urandom(), $urandom()}; pit_req_len = rand_len();
            end
            if (!data_req && (hold_both || $urandom_range(0, 3) == 0)) begin
                data_req = 1; data_req_prefix = {$urandom(), $urandom()}; data_req_len = rand_len();
            end
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    task automatic compare();
        bit pb;
        bit db;
        pb = busy && !side;
        db = busy && side;
        chk("pit_ack", 64'(pit_ack), 64'(exp_pit_ack));
        chk("data_ack", 64'(data_ack), 64'(exp_data_ack));
        chk("fib_out_bit", 64'(fib_out_bit), 64'(pb && e == g));
        chk("pit_in_prefix", pit_in_prefix, pb ? t_prefix : 64'h0);
        chk("pit_in_len", 64'(pit_in_len), pb ? 64'(t_len) : 64'h0);
        chk("data_in_prefix", data_in_prefix, db ? t_prefix : 64'h0);
        chk("data_in_len", 64'(data_in_len), db ? 64'(t_len) : 64'h0);
        chk("data_ready", 64'(data_ready), 64'(db));
        chk("pit_done", 64'(pit_done), 64'(exp_pit_done));
        chk("data_done", 64'(data_done), 64'(exp_data_done));
        if (exp_pit_done || exp_data_done) begin
            chk("done_status", 64'(done_status), 64'(exp_status));
            last_dut_status = done_status;
        end
        chk("result_prefix", result_prefix, m_res_p);
        chk("result_len", 64'(result_len), 64'(m_res_l));
        fob_count += int'(fib_out_bit);
        dr_count  += int'(data_ready);
    endtask

    task automatic step();
        drive_responder();
        gen_requests();
        @(posedge clk);
        #1;
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic run_until_done(input string name, input int budget);
        int k;
        k = 0;
        done_seen = 0;
        while (!done_seen && k < budget) begin
            step();
            k++;
        end
        chk({name, "_completes"}, 64'(done_seen), 64'h1);
    endtask

    task automatic run_until_grant(input string name, input int budget);
        int k;
        k = 0;
        grant_seen = 0;
        while (!grant_seen && k < budget) begin
            step();
            k++;
        end
        chk({name, "_granted"}, 64'(grant_seen), 64'h1);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        gen_on = 0;
        hold_both = 0;
        while ((busy || pit_req || data_req || e < free_edge) && k < budget) begin
            step();
            k++;
        end
        chk("drain_idle", 64'(busy || pit_req || data_req), 64'h0);
    endtask

    task automatic pit_request(input logic [PW-1:0] p, input logic [LW-1:0] l);
        pit_req = 1; pit_req_prefix = p; pit_req_len = l;
    endtask

    task automatic data_request(input logic [PW-1:0] p, input logic [LW-1:0] l);
        data_req = 1; data_req_prefix = p; data_req_len = l;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_pit_ack", 64'(pit_ack), 64'h0);
        chk("reset_fib_out_bit", 64'(fib_out_bit), 64'h0);
        chk("reset_data_ready", 64'(data_ready), 64'h0);
        chk("reset_done_status", 64'(done_status), 64'h0);
        chk("reset_result_prefix", result_prefix, 64'h0);
        rst = 1;

        // Outgoing lookup answered two cycles after issue.
        force_delay = 2; force_res_len = 8; fob_count = 0;
        pit_request(64'h0000FFFF0000FFFF, 6'd10);
        run_until_done("t1", 20);
        chk("t1_fob_cycles", 64'(fob_count), 64'd1);
        chk("t1_status", 64'(last_dut_status), 64'd0);
        chk("t1_result_len", 64'(result_len), 64'd8);
        chk("t1_grant_to_done", 64'(last_c - last_g), 64'd3);
        drain(20);

        // Incoming: reject after five cycles, then accept.
        force_delay = 5; force_kind = 1; force_res_len = -1; dr_count = 0;
        data_request(64'h1234, 6'd20);
        run_until_done("t2_rej", 20);
        chk("t2_ready_cycles", 64'(dr_count), 64'd6);
        chk("t2_rej_status", 64'(last_dut_status), 64'd1);
        force_kind = 2;
        data_request(64'h5678, 6'd21);
        run_until_done("t2_acc", 20);
        chk("t2_acc_status", 64'(last_dut_status), 64'd0);
        drain(20);

        // Both requesters held: grants alternate starting with PIT.
        force_delay = 1; force_kind = 2;
        grant_log.delete();
        hold_both = 1;
        begin
            int k;
            k = 0;
            while (grant_log.size() < 4 && k < 100) begin
                step();
                k++;
            end
        end
        chk("t3_grants", 64'(grant_log.size() >= 4), 64'h1);
        for (int i = 0; i < 4; i++) chk("t3_alternate", 64'(grant_log[i]), 64'(i % 2));
        drain(60);

        // No response: timeout abort, FIB inputs zero in the done cycle.
        force_delay = -1;
        pit_request(64'hDEAD, 6'd5);
        run_until_done("t4", T + 10);
        chk("t4_grant_to_done", 64'(last_c - last_g), 64'(T + 1));
        chk("t4_status", 64'(last_dut_status), 64'd2);
        chk("t4_gap_fib_out", 64'(fib_out_bit), 64'h0);
        chk("t4_gap_pit_in", pit_in_prefix, 64'h0);
        drain(20);

        // Zero length, accept+reject together, completion on the expiry cycle.
        fob_count = 0;
        pit_request(64'hBEEF, 6'd0);
        run_until_done("t5_zero", 10);
        chk("t5_zero_status", 64'(last_dut_status), 64'd1);
        chk("t5_zero_fob", 64'(fob_count), 64'd0);
        chk("t5_zero_latency", 64'(last_c - last_g), 64'd0);
        drain(20);
        force_delay = 3; force_kind = 3;
        data_request(64'hCAFE, 6'd12);
        run_until_done("t5_both", 20);
        chk("t5_both_status", 64'(last_dut_status), 64'd1);
        drain(20);
        force_delay = T;
        pit_request(64'hF00D, 6'd33);
        run_until_done("t5_edge", T + 10);
        chk("t5_edge_status", 64'(last_dut_status), 64'd0);
        chk("t5_edge_latency", 64'(last_c - last_g), 64'(T + 1));
        drain(20);

        // Reset while waiting on the FIB.
        force_delay = -1;
        pit_request(64'hA5A5A5A5A5A5A5A5, 6'd7);
        run_until_grant("t6", 10);
        step();
        step();
        #2 rst = 0;
        #1;
        chk("t6_rst_fib_out", 64'(fib_out_bit), 64'h0);
        chk("t6_rst_pit_in_prefix", pit_in_prefix, 64'h0);
        chk("t6_rst_pit_in_len", 64'(pit_in_len), 64'h0);
        chk("t6_rst_result_prefix", result_prefix, 64'h0);
        chk("t6_rst_result_len", 64'(result_len), 64'h0);
        chk("t6_rst_status", 64'(done_status), 64'h0);
        model_reset();
        pit_request(64'h1111, 6'd9);
        data_request(64'h2222, 6'd9);
        @(posedge clk);
        #1;
        chk("t6_no_done", 64'(pit_done || data_done), 64'h0);
        @(negedge clk);
        rst = 1;
        force_delay = 1; force_kind = 2;
        run_until_grant("t6_regrant", 5);
        chk("t6_first_is_pit", 64'(pit_ack), 64'h1);
        drain(40);

        // Randomized traffic.
        force_delay = -2; force_kind = -1; force_res_len = -1;
        gen_on = 1;
        repeat (2500) step();
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
